text_buffer: RTL and testbench

Character-cell screen store that sits directly upstream of `char_gen`/`char_memory` in the VGA text path. It holds one 7-bit glyph index per 8x12 cell of the 640x480 screen, written by a host over a valid/ready port. From the live `HorizontalCounter`/`VerticalCounter` it produces the glyph `address` for `char_memory`, plus the in-glyph row and column, on a fixed 2-cycle pipeline. It also runs a whole-screen clear sequencer after reset and on request.

---
 rtl/text_buffer.sv | 187 ++++++++++++++++++
 tb/tb_text_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// Character-cell screen store for the 640x480 VGA text path: host-written glyph RAM,
// whole-screen clear sequencer, and a 2-stage counter-to-glyph-address read pipeline.
module text_buffer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 40,
   parameter int CHAR_W = 8,
   parameter int CHAR_H = 12
) (
   input  logic       clock50,
   input  logic       reset_n,
   input  logic [9:0] HorizontalCounter,
   input  logic [9:0] VerticalCounter,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [6:0] wr_col,
   input  logic [5:0] wr_row,
   input  logic [7:0] wr_char,
   input  logic       clear_req,
   output logic       busy,
   output logic [6:0] address,
   output logic [3:0] glyph_row,
   output logic [2:0] glyph_col,
   output logic       pixel_valid
);

   localparam int NCELL = COLS * ROWS;
   localparam int H_VIS = COLS * CHAR_W;
   localparam int V_VIS = ROWS * CHAR_H;

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   // row*80 built from shifts so no multiplier is needed.
   function automatic logic [11:0] cell_index(input logic [11:0] row, input logic [11:0] col);
      return (row << 6) + (row << 4) + col;
   endfunction

   // Printable ASCII maps to 0..94; everything else becomes a blank cell.
   function automatic logic [6:0] map_glyph(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         return 7'(c - 8'h20);
      end
      return 7'd0;
   endfunction

   state_t      state_q;
   logic [11:0] clr_cnt_q;
   logic        busy_q;
   logic        wr_ready_q;

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_CLEAR;
         clr_cnt_q  <= 12'd0;
         busy_q     <= 1'b1;
         wr_ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_cnt_q == 12'(NCELL - 1)) begin
                  state_q    <= S_IDLE;
                  clr_cnt_q  <= 12'd0;
                  busy_q     <= 1'b0;
                  wr_ready_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 12'd1;
               end
            end
            S_IDLE: begin
               if (clear_req) begin
                  state_q    <= S_CLEAR;
                  clr_cnt_q  <= 12'd0;
                  busy_q     <= 1'b1;
                  wr_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_CLEAR;
               clr_cnt_q  <= 12'd0;
               busy_q     <= 1'b1;
               wr_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign wr_ready = wr_ready_q;

   logic        wr_hs;
   logic        wr_in_range;
   logic        mem_we;
   logic [11:0] mem_waddr;
   logic [6:0]  mem_wdata;

   assign wr_hs       = wr_valid && wr_ready_q;
   assign wr_in_range = (wr_col < 7'(COLS)) && (wr_row < 6'(ROWS));

   // Out-of-range handshakes are consumed but must not alias onto a real cell.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_q;
      mem_wdata = 7'd0;
      if (state_q == S_CLEAR) begin
         mem_we = 1'b1;
      end else if (wr_hs && wr_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = cell_index({6'd0, wr_row}, {5'd0, wr_col});
         mem_wdata = map_glyph(wr_char);
      end
   end

   // Stage 1: counters -> cell index, in-glyph position, visibility
   logic [9:0]  v_cell;
   logic [9:0]  h_cell;
   logic        vis_p0;
   logic [11:0] idx_p1_d, idx_p1_q;
   logic [3:0]  grow_p1_d, grow_p1_q;
   logic [2:0]  gcol_p1_d, gcol_p1_q;
   logic        vld_p1_d, vld_p1_q;

   always_comb begin
      v_cell    = VerticalCounter / 10'(CHAR_H);
      h_cell    = HorizontalCounter / 10'(CHAR_W);
      vis_p0    = (HorizontalCounter < 10'(H_VIS)) && (VerticalCounter < 10'(V_VIS));
      idx_p1_d  = vis_p0 ? cell_index({2'd0, v_cell}, {2'd0, h_cell}) : 12'd0;
      grow_p1_d = 4'(VerticalCounter - v_cell * 10'(CHAR_H));
      gcol_p1_d = HorizontalCounter[2:0];
      vld_p1_d  = vis_p0;
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         idx_p1_q  <= 12'd0;
         grow_p1_q <= 4'd0;
         gcol_p1_q <= 3'd0;
         vld_p1_q  <= 1'b0;
      end else begin
         idx_p1_q  <= idx_p1_d;
         grow_p1_q <= grow_p1_d;
         gcol_p1_q <= gcol_p1_d;
         vld_p1_q  <= vld_p1_d;
      end
   end

   // Stage 2: synchronous RAM read; a same-cycle write to the same cell returns old data
   logic [6:0] mem [0:NCELL-1];
   logic [6:0] rd_data_q;

   always_ff @(posedge clock50) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_data_q <= mem[idx_p1_q];
   end

   logic [3:0] grow_p2_d, grow_p2_q;
   logic [2:0] gcol_p2_d, gcol_p2_q;
   logic       vld_p2_d, vld_p2_q;

   always_comb begin
      grow_p2_d = grow_p1_q;
      gcol_p2_d = gcol_p1_q;
      vld_p2_d  = vld_p1_q;
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         grow_p2_q <= 4'd0;
         gcol_p2_q <= 3'd0;
         vld_p2_q  <= 1'b0;
      end else begin
         grow_p2_q <= grow_p2_d;
         gcol_p2_q <= gcol_p2_d;
         vld_p2_q  <= vld_p2_d;
      end
   end

   // RAM data register has no reset; the valid mask keeps address at 0 out of reset.
   assign address     = vld_p2_q ? rd_data_q : 7'd0;
   assign glyph_row   = grow_p2_q;
   assign glyph_col   = gcol_p2_q;
   assign pixel_valid = vld_p2_q;

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer: clear sequencing, host writes,
// glyph mapping, out-of-range handling and read-pipeline alignment.
module tb_text_buffer;

   logic       clock50;
   logic       reset_n;
   logic [9:0] HorizontalCounter;
   logic [9:0] VerticalCounter;
   logic       wr_valid;
   logic       wr_ready;
   logic [6:0] wr_col;
   logic [5:0] wr_row;
   logic [7:0] wr_char;
   logic       clear_req;
   logic       busy;
   logic [6:0] address;
   logic [3:0] glyph_row;
   logic [2:0] glyph_col;
   logic       pixel_valid;

   int errors = 0;
   int checks = 0;

   text_buffer dut (
      .clock50          (clock50),
      .reset_n          (reset_n),
      .HorizontalCounter(HorizontalCounter),
      .VerticalCounter  (VerticalCounter),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .wr_col           (wr_col),
      .wr_row           (wr_row),
      .wr_char          (wr_char),
      .clear_req        (clear_req),
      .busy             (busy),
      .address          (address),
      .glyph_row        (glyph_row),
      .glyph_col        (glyph_col),
      .pixel_valid      (pixel_valid)
   );

   initial clock50 = 1'b0;
   always #5 clock50 = ~clock50;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock50);
      #1;
   endtask

   task automatic read_pix(input int h, input int v, output logic [6:0] a, output logic [3:0] gr,
                           output logic [2:0] gc, output logic pv);
      HorizontalCounter = 10'(h);
      VerticalCounter   = 10'(v);
      tick();
      tick();
      a  = address;
      gr = glyph_row;
      gc = glyph_col;
      pv = pixel_valid;
   endtask

   task automatic read_cell(input int col, input int row, output logic [6:0] a);
      logic [3:0] gr;
      logic [2:0] gc;
      logic       pv;
      read_pix(col * 8, row * 12, a, gr, gc, pv);
   endtask

   task automatic do_write(input int col, input int row, input logic [7:0] ch, output logic acc);
      wr_valid = 1'b1;
      wr_col   = 7'(col);
      wr_row   = 6'(row);
      wr_char  = ch;
      acc      = wr_ready;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_busy(input int pulse_at, output int n, output int bad_rdy);
      n       = 0;
      bad_rdy = 0;
      while (busy === 1'b1 && n < 5000) begin
         if (wr_ready !== 1'b0) bad_rdy++;
         n++;
         clear_req = (n == pulse_at);
         tick();
      end
      clear_req = 1'b0;
   endtask

   task automatic test_reset();
      int         n, bad_rdy, bad_cells;
      logic [6:0] a;
      logic [3:0] gr;
      logic [2:0] gc;
      logic       pv;
      reset_n           = 1'b0;
      HorizontalCounter = 10'd13;
      VerticalCounter   = 10'd17;
      repeat (3) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      checks++; if (address !== 7'd0) begin errors++; $display("FAIL reset_address: got %0d want 0", address); end
      checks++; if (glyph_row !== 4'd0) begin errors++; $display("FAIL reset_glyph_row: got %0d want 0", glyph_row); end
      checks++; if (glyph_col !== 3'd0) begin errors++; $display("FAIL reset_glyph_col: got %0d want 0", glyph_col); end
      checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
      reset_n = 1'b1;
      wait_busy(-1, n, bad_rdy);
      checks++; if (n !== 3200) begin errors++; $display("FAIL post_reset_clear_len: got %0d want 3200", n); end
      checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL ready_during_clear: got %0d cycles want 0", bad_rdy); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear: got %b want 1", wr_ready); end
      bad_cells = 0;
      for (int r = 0; r < 40; r++) begin
         for (int c = 0; c < 80; c++) begin
            read_pix(c * 8 + (c % 8), r * 12 + (r % 12), a, gr, gc, pv);
            if (a !== 7'd0 || pv !== 1'b1) bad_cells++;
         end
      end
      checks++; if (bad_cells !== 0) begin errors++; $display("FAIL frame_blank: got %0d nonzero cells want 0", bad_cells); end
   endtask

   task automatic test_write_glyph();
      logic       acc;
      logic [6:0] a;
      logic [3:0] gr;
      logic [2:0] gc;
      logic       pv;
      int         nb_c[4] = '{4, 6, 5, 5};
      int         nb_r[4] = '{2, 2, 1, 3};
      do_write(5, 2, 8'h41, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL write_A_accept: got %b want 1", acc); end
      for (int v = 24; v <= 35; v++) begin
         for (int h = 40; h <= 47; h++) begin
            read_pix(h, v, a, gr, gc, pv);
            checks++; if (a !== 7'd33) begin errors++; $display("FAIL cell_A_addr h=%0d v=%0d: got %0d want 33", h, v, a); end
            checks++; if (gc !== 3'(h - 40)) begin errors++; $display("FAIL cell_A_col h=%0d v=%0d: got %0d want %0d", h, v, gc, h - 40); end
            checks++; if (gr !== 4'(v - 24)) begin errors++; $display("FAIL cell_A_row h=%0d v=%0d: got %0d want %0d", h, v, gr, v - 24); end
            checks++; if (pv !== 1'b1) begin errors++; $display("FAIL cell_A_valid h=%0d v=%0d: got %b want 1", h, v, pv); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         read_cell(nb_c[i], nb_r[i], a);
         checks++; if (a !== 7'd0) begin errors++; $display("FAIL neighbour (%0d,%0d): got %0d want 0", nb_c[i], nb_r[i], a); end
      end
   endtask

   task automatic test_invalid_char();
      logic       acc;
      logic [6:0] a;
      do_write(0, 0, 8'h41, acc);
      read_cell(0, 0, a);
      checks++; if (a !== 7'd33) begin errors++; $display("FAIL cell00_A: got %0d want 33", a); end
      do_write(0, 0, 8'h07, acc);
      read_cell(0, 0, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL cell00_ctrl: got %0d want 0", a); end
      do_write(1, 0, 8'h7F, acc);
      read_cell(1, 0, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL cell10_del: got %0d want 0", a); end
      do_write(2, 0, 8'h20, acc);
      read_cell(2, 0, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL cell20_space: got %0d want 0", a); end
      do_write(79, 39, 8'h7E, acc);
      read_cell(79, 39, a);
      checks++; if (a !== 7'd94) begin errors++; $display("FAIL cell_79_39_tilde: got %0d want 94", a); end
   endtask

   task automatic test_out_of_range();
      logic       acc;
      logic [6:0] a;
      do_write(80, 0, 8'h42, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL oor_col80_accept: got %b want 1", acc); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oor_ready_after: got %b want 1", wr_ready); end
      read_cell(0, 1, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL oor_col80_alias: got %0d want 0", a); end
      do_write(127, 0, 8'h42, acc);
      read_cell(47, 1, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL oor_col127_alias: got %0d want 0", a); end
      do_write(0, 63, 8'h42, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL oor_row63_accept: got %b want 1", acc); end
      read_cell(64, 11, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL oor_row63_alias: got %0d want 0", a); end
   endtask

   task automatic test_back_to_back();
      int         acc_cnt;
      logic [6:0] a;
      acc_cnt  = 0;
      wr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_col  = 7'(10 + i);
         wr_row  = 6'd5;
         wr_char = 8'(8'h30 + i);
         if (wr_ready === 1'b1) acc_cnt++;
         tick();
      end
      wr_valid = 1'b0;
      checks++; if (acc_cnt !== 10) begin errors++; $display("FAIL burst_accepted: got %0d want 10", acc_cnt); end
      for (int i = 0; i < 10; i++) begin
         read_cell(10 + i, 5, a);
         checks++; if (a !== 7'(16 + i)) begin errors++; $display("FAIL burst_cell%0d: got %0d want %0d", i, a, 16 + i); end
      end
   endtask

   task automatic test_latency();
      logic       acc;
      logic [6:0] a;
      logic [3:0] gr;
      logic [2:0] gc;
      logic       pv;
      read_pix(0, 0, a, gr, gc, pv);
      HorizontalCounter = 10'd45;
      VerticalCounter   = 10'd30;
      tick();
      checks++; if (address !== 7'd0) begin errors++; $display("FAIL latency_1clk_addr: got %0d want 0", address); end
      checks++; if (glyph_col !== 3'd0) begin errors++; $display("FAIL latency_1clk_col: got %0d want 0", glyph_col); end
      tick();
      checks++; if (address !== 7'd33) begin errors++; $display("FAIL latency_2clk_addr: got %0d want 33", address); end
      checks++; if (glyph_col !== 3'd5 || glyph_row !== 4'd6) begin errors++; $display("FAIL latency_2clk_pos: got col %0d row %0d want col 5 row 6", glyph_col, glyph_row); end
      do_write(20, 20, 8'h45, acc);
      read_cell(20, 20, a);
      checks++; if (a !== 7'd37) begin errors++; $display("FAIL read_after_write: got %0d want 37", a); end
   endtask

   task automatic test_visibility();
      logic       acc;
      logic [6:0] a;
      logic [3:0] gr;
      logic [2:0] gc;
      logic       pv;
      do_write(0, 1, 8'h43, acc);
      read_pix(640, 0, a, gr, gc, pv);
      checks++; if (pv !== 1'b0 || a !== 7'd0) begin errors++; $display("FAIL h640: got valid %b addr %0d want 0 0", pv, a); end
      read_pix(0, 480, a, gr, gc, pv);
      checks++; if (pv !== 1'b0 || a !== 7'd0) begin errors++; $display("FAIL v480: got valid %b addr %0d want 0 0", pv, a); end
      read_pix(1023, 1023, a, gr, gc, pv);
      checks++; if (pv !== 1'b0 || a !== 7'd0) begin errors++; $display("FAIL hv_max: got valid %b addr %0d want 0 0", pv, a); end
      read_pix(639, 479, a, gr, gc, pv);
      checks++; if (pv !== 1'b1 || a !== 7'd94) begin errors++; $display("FAIL last_pixel: got valid %b addr %0d want 1 94", pv, a); end
      checks++; if (gr !== 4'd11 || gc !== 3'd7) begin errors++; $display("FAIL last_pixel_pos: got row %0d col %0d want 11 7", gr, gc); end
      read_pix(0, 12, a, gr, gc, pv);
      checks++; if (pv !== 1'b1 || a !== 7'd35) begin errors++; $display("FAIL cell01_C: got valid %b addr %0d want 1 35", pv, a); end
   endtask

   task automatic test_clear_req();
      int         n, bad_rdy;
      logic [6:0] a;
      wr_valid  = 1'b1;
      wr_col    = 7'd3;
      wr_row    = 6'd3;
      wr_char   = 8'h5A;
      clear_req = 1'b1;
      tick();
      wr_valid  = 1'b0;
      clear_req = 1'b0;
      checks++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL clear_start: got busy %b ready %b want 1 0", busy, wr_ready); end
      wait_busy(100, n, bad_rdy);
      checks++; if (n !== 3200) begin errors++; $display("FAIL clear_req_len: got %0d want 3200", n); end
      checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL clear_req_ready: got %0d cycles want 0", bad_rdy); end
      read_cell(3, 3, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL clear_cell33: got %0d want 0", a); end
      read_cell(5, 2, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL clear_cell52: got %0d want 0", a); end
      read_cell(79, 39, a);
      checks++; if (a !== 7'd0) begin errors++; $display("FAIL clear_cell_79_39: got %0d want 0", a); end
   endtask

   task automatic test_reset_mid_clear();
      int n, bad_rdy;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (1500) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy: got %b want 1", busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b1 || wr_ready !== 1'b0 || pixel_valid !== 1'b0) begin
         errors++; $display("FAIL mid_clear_reset: got busy %b ready %b valid %b want 1 0 0", busy, wr_ready, pixel_valid);
      end
      tick();
      tick();
      reset_n = 1'b1;
      wait_busy(-1, n, bad_rdy);
      checks++; if (n !== 3200) begin errors++; $display("FAIL restart_clear_len: got %0d want 3200", n); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b want 1", wr_ready); end
   endtask

   initial begin
      reset_n           = 1'b0;
      HorizontalCounter = 10'd0;
      VerticalCounter   = 10'd0;
      wr_valid          = 1'b0;
      wr_col            = 7'd0;
      wr_row            = 6'd0;
      wr_char           = 8'd0;
      clear_req         = 1'b0;
      test_reset();
      test_write_glyph();
      test_invalid_char();
      test_out_of_range();
      test_back_to_back();
      test_latency();
      test_visibility();
      test_clear_req();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
